// File: rtl/step_decoder.sv
// step_decoder: synchronizes step/dir pins, tracks a signed position and
// estimates velocity as 2^FRAC_BITS / step period with a serial divider.
module step_decoder #(
  parameter int          FRAC_BITS = 24,
  parameter logic [31:0] TIMEOUT   = 32'd16777215
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step_in,
  input  logic               dir_in,
  input  logic               pos_load,
  input  logic signed [31:0] pos_load_value,
  output logic signed [31:0] position,
  output logic signed [31:0] velocity,
  output logic               vel_valid,
  output logic               step_evt,
  output logic               stalled,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state, state_n;
  logic s1, s2, s3, d1, d2, have_prev, last_dir, neg, done;
  logic evt, in_time, start, rev, tmo, ge;
  logic [31:0] cnt, q, r, dvs;
  logic [32:0] r_sh;
  logic [4:0] it;
  logic signed [31:0] delta;
  always_comb begin
    evt = s2 & ~s3;
    in_time = have_prev && cnt < TIMEOUT;
    start = evt && in_time && d2 == last_dir;
    rev = evt && in_time && d2 != last_dir;
    tmo = have_prev && !evt && cnt == TIMEOUT - 32'd1;
    delta = evt ? (d2 ? 32'sd1 : -32'sd1) : 32'sd0;
    r_sh = {r, q[31]};
    ge = r_sh >= {1'b0, dvs};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // A new event always wins: valid periods restart the divider, invalid ones abort it.
  always_comb
    state_n = tmo ? IDLE :
              evt ? (start ? DIV : IDLE) :
              state == DONE ? IDLE :
              (state == DIV && it == 5'd31) ? DONE : state;
  always_comb begin
    busy = state == DIV;
    done = state == DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {s1, s2, s3, d1, d2} <= '0;
      position <= '0;
      velocity <= '0;
      vel_valid <= 1'b0;
      step_evt <= 1'b0;
      stalled <= 1'b1;
      cnt <= '0;
      have_prev <= 1'b0;
      last_dir <= 1'b0;
      neg <= 1'b0;
      q <= '0;
      r <= '0;
      dvs <= '0;
      it <= '0;
    end else begin
      s1 <= step_in;
      s2 <= s1;
      s3 <= s2;
      d1 <= dir_in;
      d2 <= d1;
      step_evt <= evt;
      position <= (pos_load ? pos_load_value : position) + delta;
      cnt <= evt ? 32'd1 : cnt < TIMEOUT ? cnt + 32'd1 : cnt;
      vel_valid <= 1'b0;
      if (evt) begin
        have_prev <= 1'b1;
        last_dir <= d2;
      end
      if (start) begin
        r <= '0;
        q <= 32'd1 << FRAC_BITS;
        dvs <= cnt;
        it <= '0;
        neg <= ~d2;
      end else if (busy) begin
        r <= ge ? r_sh[31:0] - dvs : r_sh[31:0];
        q <= {q[30:0], ge};
        it <= it + 5'd1;
      end
      if (tmo || rev) begin
        velocity <= '0;
        vel_valid <= 1'b1;
        stalled <= 1'b1;
      end else if (done) begin
        velocity <= neg ? -q : q;
        vel_valid <= 1'b1;
        stalled <= 1'b0;
      end
    end
endmodule

// File: doc/step_decoder.md
# step_decoder

Receiving end of the step/dir interface driven by `step_gen`. It synchronizes external `step`/`dir` inputs and keeps a signed 32-bit position count. It also reconstructs a velocity estimate in the same fixed-point format as the `step_gen` `velocity` input, so loopback or encoder-style feedback can be compared directly against commanded motion. It sits between the motor-driver pins (or a `step_gen` loopback) and the motion-control registers.

## Interface
- `FRAC_BITS`, 24: fractional bits of velocity. Velocity = steps per clock × 2^FRAC_BITS. Legal range 1..30.
- `TIMEOUT`, 16777215: clocks without a step before velocity is forced to 0. Legal range 2..2^32-1.
- `clk` in 1: single clock for the whole block.
- `reset` in 1: asynchronous, active-high; returns every register to its reset value.
- `step_in` in 1: asynchronous step input; a rising edge is one step.
- `dir_in` in 1: asynchronous direction; 1 = positive, 0 = negative. Same polarity as `step_gen` `dir`.
- `pos_load` in 1: synchronous load strobe for position.
- `pos_load_value` in 32 signed: value loaded on `pos_load`.
- `position` out 32 signed: accumulated step count, wraps modulo 2^32.
- `velocity` out 32 signed: measured velocity, FRAC_BITS fraction.
- `vel_valid` out 1: one-cycle pulse when `velocity` is updated.
- `step_evt` out 1: one-cycle pulse per detected step.
- `stalled` out 1: high while no valid period measurement exists.
- `busy` out 1: divider running.

## Operation
- **Input synchronization:**
  - `step_in` and `dir_in` each pass through a 2-FF synchronizer.
  - A third `step` register provides edge detection. A step event is synchronized step = 1 while the history register = 0.
  - The direction of an event is the synchronized `dir` in the event cycle.
- **Position:**
  - On an event, `position` changes by ±1. No saturation: 32'h7FFFFFFF + 1 wraps to 32'h80000000.
  - `pos_load` with no event loads `pos_load_value`.
  - `pos_load` in the same cycle as an event loads `pos_load_value` ±1, so the step is not lost.
- **Period counter:**
  - 32-bit unsigned. It is set to 1 on every event. Otherwise it increments, saturating at TIMEOUT.
  - At an event, the counter value equals the number of clocks since the previous event.
- **Measurement qualification, checked at each event:**
  - A period is valid only if a previous event exists since reset, the counter is below TIMEOUT, and the direction equals the previous event's direction.
  - If the period is valid: the divider starts with divisor = period and dividend = 2^FRAC_BITS.
  - If the period is invalid because of a direction change: `velocity` becomes 0, `vel_valid` pulses, `stalled` = 1, and no division is started.
  - If the period is invalid because there is no previous event or the counter has timed out: `stalled` stays 1 and no division is started.
- **Divider FSM:**
  - States IDLE → DIV → DONE → IDLE.
  - Radix-2 restoring divider, 32 iterations, one iteration per clock in DIV.
  - DONE registers `velocity` = +quotient or −quotient using the latched direction, pulses `vel_valid`, clears `stalled`, and returns to IDLE.
  - Quotient is the floor of the division. No saturation is needed, since quotient ≤ 2^29.
  - An event arriving while in DIV aborts and restarts the divider with the new period, or aborts to IDLE if the new period is invalid.
- **Timeout:**
  - When the counter first reaches TIMEOUT: `velocity` becomes 0, `vel_valid` pulses once, `stalled` = 1, and any running division is aborted.

## Timing
- Reset values:
  - `position` 0, `velocity` 0, `vel_valid` 0, `step_evt` 0, `busy` 0, FSM IDLE.
  - `stalled` 1, period counter 0, "previous event exists" flag 0, synchronizers 0.
- Step latency: `step_evt` and the `position` update occur at the 3rd rising `clk` edge after `step_in` is first sampled high.
- Event-to-velocity latency:
  - Event registered at edge E; `busy` is high from E+1 through E+32.
  - `velocity` and `vel_valid` are updated at edge E+33.
- Minimum step period is 2 clocks (step high ≥1 clk, low ≥1 clk at the synchronizer). The period is therefore always ≥2 and the divisor is never 0.
- Reset asserted mid-division: all state clears asynchronously. The first event after reset is unqualified.

## Test plan
- Reset, then 10 rising edges of `step_in` with `dir_in` = 1, 64 clocks apart → `position` = 10. Nine `vel_valid` pulses with `velocity` = 32'h00040000; `stalled` goes 0 after the 2nd event.
- Loopback with `step_gen`, velocity = 32'h40000 then −32'h40000 → `position` ramps up then down. `velocity` tracks 0x40000, goes to 0 on the reversal, then settles at −0x40000 (32'hFFFC0000) after the second reversed step.
- Steps 3 clocks apart → `velocity` = 2^24/3 = 32'h00555555. A step arriving mid-division restarts the divider; `vel_valid` occurs only 33 clocks after the last event.
- Stop stepping with TIMEOUT = 1000 → exactly 1000 clocks after the last event counter saturates: `velocity` = 0, one `vel_valid` pulse, `stalled` = 1. The next single step gives no velocity update.
- `pos_load` = 32'h7FFFFFFF coincident with a positive step → `position` = 32'h80000000. `pos_load` alone with value −5 → `position` = −5.
- Assert `reset` at E+10 during a division → all outputs return to reset values immediately. `busy` = 0 and no `vel_valid` follows.
